// File: rtl/bounce_gen.sv
// Emulated bouncy push-button: odd number of LFSR-paced toggles to the target level, then a settle hold and a done pulse.
// Optional BOUNCE_GEN_COUNT_EN adds a saturating toggle_count output counting every button_out edge since reset.
module bounce_gen #(
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int          NB_W          = 3,
   parameter int          GAP_W         = 4,
   parameter int          SETTLE_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   input  logic        cmd_level,
   output logic        cmd_ready,
   output logic        button_out,
   output logic        busy,
   output logic        done
`ifdef BOUNCE_GEN_COUNT_EN
   ,
   output logic [15:0] toggle_count
`endif
);

   localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam int          SET_W     = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BOUNCE,
      S_SETTLE
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic               btn_q, btn_d;
   logic [NB_W-1:0]    tog_q, tog_d;
   logic [GAP_W:0]     gap_q, gap_d;
   logic [SET_W-1:0]   set_q, set_d;
   logic               done_q, done_d;

   logic [NB_W-1:0]    tog_new;
   logic [GAP_W:0]     gap_new;

   // Toggle count is the LFSR low bits shifted up with a forced 1 below, so it is always odd.
   if (NB_W == 1) begin : g_tog1
      assign tog_new = 1'b1;
   end else begin : g_togn
      assign tog_new = {lfsr_q[NB_W-2:0], 1'b1};
   end

   assign gap_new = (GAP_W+1)'(lfsr_q[GAP_W+7:8]) + (GAP_W+1)'(1);

   always_comb begin
      state_d = state_q;
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      btn_d   = btn_q;
      tog_d   = tog_q;
      gap_d   = gap_q;
      set_d   = set_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_level == btn_q) begin
                  state_d = S_SETTLE;
                  set_d   = SET_INIT;
               end else begin
                  tog_d   = tog_new;
                  gap_d   = gap_new;
                  state_d = S_BOUNCE;
               end
            end
         end
         S_BOUNCE: begin
            gap_d = gap_q - (GAP_W+1)'(1);
            if (gap_q == (GAP_W+1)'(1)) begin
               btn_d = ~btn_q;
               tog_d = tog_q - NB_W'(1);
               if (tog_q == NB_W'(1)) begin
                  state_d = S_SETTLE;
                  set_d   = SET_INIT;
               end else begin
                  gap_d = gap_new;
               end
            end
         end
         S_SETTLE: begin
            // done is registered, so it lands in the first IDLE cycle where a new command can be taken.
            if (set_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               set_d = set_q - SET_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED_EFF;
         btn_q   <= 1'b0;
         tog_q   <= '0;
         gap_q   <= '0;
         set_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         btn_q   <= btn_d;
         tog_q   <= tog_d;
         gap_q   <= gap_d;
         set_q   <= set_d;
         done_q  <= done_d;
      end
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign button_out = btn_q;
   assign done       = done_q;

`ifdef BOUNCE_GEN_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((btn_d != btn_q) && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign toggle_count = cnt_q;
`endif

endmodule

// File: tb/tb_bounce_gen.sv
// Randomized bench for bounce_gen: a schedule model predicts every toggle edge and the done cycle per command.
`timescale 1ns/1ps
module tb_bounce_gen;

   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        vld [2];
   logic        lvl [2];
   logic        rdy [2];
   logic        btn [2];
   logic        bsy [2];
   logic        dn  [2];
`ifdef BOUNCE_GEN_COUNT_EN
   logic [15:0] tcnt [2];
`endif

   bounce_gen #(.SEED(SEED), .NB_W(3), .GAP_W(4), .SETTLE_CYCLES(32)) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(vld[0]), .cmd_level(lvl[0]),
      .cmd_ready(rdy[0]), .button_out(btn[0]), .busy(bsy[0]), .done(dn[0])
`ifdef BOUNCE_GEN_COUNT_EN
      , .toggle_count(tcnt[0])
`endif
   );

   bounce_gen #(.SEED(SEED), .NB_W(3), .GAP_W(4), .SETTLE_CYCLES(0)) dut_z (
      .clk(clk), .reset_n(reset_n), .cmd_valid(vld[1]), .cmd_level(lvl[1]),
      .cmd_ready(rdy[1]), .button_out(btn[1]), .busy(bsy[1]), .done(dn[1])
`ifdef BOUNCE_GEN_COUNT_EN
      , .toggle_count(tcnt[1])
`endif
   );

   int          total = 0;
   int          bad   = 0;
   logic [15:0] m_lfsr [2];
   logic        m_lvl  [2];
   int          obs_sum [2];
   int          n_first, n_again, n_tmp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic int gap_of(input logic [15:0] v);
      return int'(v[11:8]) + 1;
   endfunction

   function automatic int tog_of(input logic [15:0] v);
      return 2 * int'(v[1:0]) + 1;
   endfunction

   function automatic int settle_of(input int u);
      return (u == 0) ? 32 : 0;
   endfunction

   task automatic tick();
      @(negedge clk);
      for (int u = 0; u < 2; u++) m_lfsr[u] = lstep(m_lfsr[u]);
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_lfsr[u]  = SEED;
         m_lvl[u]   = 1'b0;
         obs_sum[u] = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         vld[0] = 1'b0;
         vld[1] = 1'b0;
         tick();
         for (int u = 0; u < 2; u++) begin
            check("idle_ready", rdy[u], 1);
            check("idle_btn", btn[u], m_lvl[u]);
            check("idle_done", dn[u], 0);
         end
      end
   endtask

   // Offsets count negedges after the one where the command is presented.
   task automatic run_cmd(input int u, input logic level, input bit noise, input bit hold, output int ntog);
      int          tt[$];
      int          s, g, te, n, done_at, idx, obs;
      logic [15:0] vv;
      logic        exp_b, prev_b;
      check("start_ready", rdy[u], 1);
      check("start_btn", btn[u], m_lvl[u]);
      n = 0;
      if (level != m_lvl[u]) begin
         vv = m_lfsr[u];
         n  = tog_of(vv);
         s  = 0;
         for (int i = 0; i < n; i++) begin
            g  = gap_of(vv);
            te = s + g + 1;
            tt.push_back(te);
            for (int j = 0; j < g; j++) vv = lstep(vv);
            s = te - 1;
         end
         done_at = tt[n-1] + settle_of(u) + 1;
      end else begin
         done_at = settle_of(u) + 2;
      end
      vld[u] = 1'b1;
      lvl[u] = level;
      exp_b  = m_lvl[u];
      prev_b = m_lvl[u];
      idx    = 0;
      obs    = 0;
      for (int k = 1; k <= done_at; k++) begin
         tick();
         if (noise && k < done_at) begin
            vld[u] = 1'($urandom_range(0, 1));
            lvl[u] = ~level;
         end else if (!hold) begin
            vld[u] = 1'b0;
         end
         while (idx < tt.size() && tt[idx] == k) begin
            exp_b = ~exp_b;
            idx++;
         end
         if (btn[u] !== prev_b) obs++;
         prev_b = btn[u];
         check("btn", btn[u], exp_b);
         check("done", dn[u], k == done_at);
         check("ready", rdy[u], k == done_at);
         check("busy", bsy[u], k != done_at);
      end
      check("toggle_total", obs, n);
      check("toggle_parity", obs % 2, level != m_lvl[u]);
      check("final_level", btn[u], level);
      m_lvl[u]    = level;
      obs_sum[u] += obs;
      ntog        = obs;
`ifdef BOUNCE_GEN_COUNT_EN
      check("toggle_count", tcnt[u], (obs_sum[u] > 65535) ? 65535 : obs_sum[u]);
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         vld[u] = 1'b0;
         lvl[u] = 1'b0;
      end
      model_reset();
      #12;
      for (int u = 0; u < 2; u++) begin
         check("rst_btn", btn[u], 0);
         check("rst_ready", rdy[u], 1);
         check("rst_busy", bsy[u], 0);
         check("rst_done", dn[u], 0);
`ifdef BOUNCE_GEN_COUNT_EN
         check("rst_count", tcnt[u], 0);
`endif
      end
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();

      // First transition from fresh reset, then same-level command back-to-back.
      idle(3);
      run_cmd(0, 1'b1, 1'b0, 1'b0, n_first);
      run_cmd(0, 1'b1, 1'b0, 1'b0, n_tmp);
      check("same_level_no_toggle", n_tmp, 0);

      // Random commands with ignored requests sprayed during busy.
      for (int i = 0; i < 8; i++) begin
         run_cmd(0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, n_tmp);
         idle($urandom_range(0, 3));
      end

      // Asynchronous reset during BOUNCE.
      if (m_lvl[0] == 1'b1) run_cmd(0, 1'b0, 1'b0, 1'b0, n_tmp);
      vld[0] = 1'b1;
      lvl[0] = 1'b1;
      @(posedge clk);
      #2;
      check("pre_abort_busy", bsy[0], 1);
      reset_n = 1'b0;
      #1;
      check("abort_btn", btn[0], 0);
      check("abort_ready", rdy[0], 1);
      check("abort_busy", bsy[0], 0);
      check("abort_done", dn[0], 0);
      vld[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_rst_done", dn[0], 0);
         check("hold_rst_btn", btn[0], 0);
      end
      reset_n = 1'b1;
      model_reset();
      idle(3);
      run_cmd(0, 1'b1, 1'b0, 1'b0, n_again);
      check("reseed_same_toggles", n_again, n_first);

      // Zero settle window, command held high, level alternating.
      for (int i = 0; i < 100; i++) begin
         run_cmd(1, (i % 2 == 0) ? 1'b0 : 1'b1, 1'b0, 1'b1, n_tmp);
      end
      vld[1] = 1'b0;
      idle(2);

`ifdef BOUNCE_GEN_COUNT_EN
      for (int i = 0; i < 100; i++) begin
         run_cmd(0, ~m_lvl[0], 1'b0, 1'b0, n_tmp);
      end
      idle(1);
      force dut.cnt_q = 16'hFFFE;
      tick();
      release dut.cnt_q;
      obs_sum[0] = 65534;
      idle(1);
      check("count_forced", tcnt[0], 16'hFFFE);
      run_cmd(0, ~m_lvl[0], 1'b0, 1'b0, n_tmp);
      run_cmd(0, ~m_lvl[0], 1'b0, 1'b0, n_tmp);
      check("count_saturated", tcnt[0], 16'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
